// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the encoder, LIF neuron and display logic
package lif_pkg;

   localparam int         LIF_WIDTH     = 8;
   localparam logic [7:0] LIF_AMPLITUDE = 8'd200;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } lif_state_e;

   typedef enum logic {
      MODE_RATE  = 1'b0,
      MODE_DELTA = 1'b1
   } enc_mode_e;

endpackage

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - rate/delta spike encoder driving the LIF neuron current input
module spike_encoder
   import lif_pkg::*;
#(
   parameter int               WIDTH     = LIF_WIDTH,
   parameter int               WINDOW    = 16,
   parameter logic [WIDTH-1:0] AMPLITUDE = WIDTH'(LIF_AMPLITUDE),
   parameter logic [WIDTH-1:0] DELTA_THR = WIDTH'(16)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_value,
   input  logic             i_mode,
   input  logic             i_step_en,
   output logic             o_spike,
   output logic             o_spike_neg,
   output logic [WIDTH-1:0] o_current,
   output logic [8:0]       o_spike_count,
   output logic             o_window_done
);

   localparam int             CNT_W = $clog2(WINDOW + 1);
   localparam logic [WIDTH:0] ONE   = (WIDTH + 1)'(1);

   lif_state_e       r_state;
   enc_mode_e        r_md;
   logic [WIDTH-1:0] r_val;
   logic [WIDTH-1:0] r_last_val;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_step_cnt;
   logic [8:0]       r_spike_count;
   logic             r_spike;
   logic             r_spike_neg;
   logic [WIDTH-1:0] r_current;
   logic             r_window_done;

   logic             w_accept;
   logic             w_step0;
   logic             w_last_step;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_abs;
   logic             w_spike;
   logic             w_spike_neg;

   assign o_in_ready  = (r_state != RUN);
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_step0     = (r_step_cnt == '0);
   assign w_last_step = (r_step_cnt == CNT_W'(WINDOW - 1));

   // Phase accumulator: the carry out of acc+val is the rate-coded spike.
   assign w_sum  = {1'b0, r_acc} + {1'b0, r_val};
   // Two's-complement difference; bit WIDTH is the sign.
   assign w_diff = {1'b0, r_val} - {1'b0, r_last_val};
   assign w_abs  = w_diff[WIDTH] ? (~w_diff + ONE) : w_diff;

   assign w_spike     = (r_md == MODE_RATE) ? w_sum[WIDTH]
                                            : (w_step0 && (w_abs >= {1'b0, DELTA_THR}));
   assign w_spike_neg = (r_md == MODE_DELTA) && w_step0 && w_diff[WIDTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_md          <= MODE_RATE;
         r_val         <= '0;
         r_last_val    <= '0;
         r_acc         <= '0;
         r_step_cnt    <= '0;
         r_spike_count <= '0;
         r_spike       <= 1'b0;
         r_spike_neg   <= 1'b0;
         r_current     <= '0;
         r_window_done <= 1'b0;
      end else begin
         r_window_done <= 1'b0;
         if (w_accept) begin
            // Spike outputs stay untouched so a back-to-back window holds the last step.
            r_state       <= RUN;
            r_val         <= i_in_value;
            r_md          <= enc_mode_e'(i_mode);
            r_acc         <= '0;
            r_step_cnt    <= '0;
            r_spike_count <= '0;
         end else begin
            case (r_state)
               RUN: begin
                  if (i_step_en) begin
                     if (r_md == MODE_RATE) begin
                        r_acc <= w_sum[WIDTH-1:0];
                     end else if (w_step0) begin
                        r_last_val <= r_val;
                     end
                     r_spike     <= w_spike;
                     r_spike_neg <= w_spike_neg;
                     r_current   <= w_spike ? AMPLITUDE : '0;
                     if (w_spike && (r_spike_count != 9'd511)) begin
                        r_spike_count <= r_spike_count + 9'd1;
                     end
                     r_step_cnt <= r_step_cnt + CNT_W'(1);
                     if (w_last_step) begin
                        r_state       <= DONE;
                        r_window_done <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  r_state     <= IDLE;
                  r_spike     <= 1'b0;
                  r_spike_neg <= 1'b0;
                  r_current   <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_spike       = r_spike;
   assign o_spike_neg   = r_spike_neg;
   assign o_current     = r_current;
   assign o_spike_count = r_spike_count;
   assign o_window_done = r_window_done;

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - scoreboard bench for spike_encoder
module tb_spike_encoder;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_value = 8'd0;
   logic       mode     = 1'b0;
   logic       step_en  = 1'b0;
   logic       in_ready;
   logic       spike;
   logic       spike_neg;
   logic [7:0] current;
   logic [8:0] spike_count;
   logic       window_done;

   always #5 clk = ~clk;

   spike_encoder dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_value    (in_value),
      .i_mode        (mode),
      .i_step_en     (step_en),
      .o_spike       (spike),
      .o_spike_neg   (spike_neg),
      .o_current     (current),
      .o_spike_count (spike_count),
      .o_window_done (window_done)
   );

   typedef struct {
      logic       s;
      logic       n;
      logic [7:0] c;
   } step_t;

   step_t q_step[$];
   int    q_win[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: record at each edge whether a counted step was offered, compare on the next falling edge.
   logic  cap_step  = 1'b0;
   logic  prev_done = 1'b0;
   step_t held      = '{1'b0, 1'b0, 8'd0};
   step_t e;
   int    exp_cnt   = 0;
   int    wc;

   always @(posedge clk) cap_step = !rst && step_en && !in_ready;

   always @(negedge clk) begin
      if (rst) begin
         held      = '{1'b0, 1'b0, 8'd0};
         exp_cnt   = 0;
         prev_done = 1'b0;
      end else begin
         if (cap_step) begin
            if (q_step.size() == 0) begin
               chk("step_queue_nonempty", 0, 1);
            end else begin
               e = q_step.pop_front();
               chk("step_spike", spike, e.s);
               chk("step_spike_neg", spike_neg, e.n);
               chk("step_current", current, e.c);
               held = e;
            end
         end else if (!in_ready) begin
            chk("hold_spike", spike, held.s);
            chk("hold_spike_neg", spike_neg, held.n);
            chk("hold_current", current, held.c);
         end else if (!window_done) begin
            chk("idle_spike", spike, 0);
            chk("idle_spike_neg", spike_neg, 0);
            chk("idle_current", current, 0);
            chk("idle_spike_count", spike_count, exp_cnt);
            held = '{1'b0, 1'b0, 8'd0};
         end
         if (window_done) begin
            chk("done_one_cycle", prev_done, 0);
            if (q_win.size() == 0) begin
               chk("unexpected_window_done", 1, 0);
            end else begin
               wc = q_win.pop_front();
               chk("window_spike_count", spike_count, wc);
               exp_cnt = wc;
            end
         end
         prev_done = window_done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // step_en is raised with the handshake to confirm that strobe is not counted.
   task automatic accept(input logic [7:0] v, input logic m, input bit b2b);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk("accept_ready", in_ready, 1);
      if (b2b) chk("b2b_from_done", window_done, 1);
      in_valid = 1'b1;
      in_value = v;
      mode     = m;
      step_en  = 1'b1;
      tick();
      in_valid = 1'b0;
      step_en  = 1'b0;
      chk("accepted_now_run", in_ready, 0);
   endtask

   task automatic window(input logic [7:0] v, input logic m, input logic [15:0] mask,
                         input logic [15:0] negm, input int cnt, input int gap,
                         input bit b2b, input bit poke);
      accept(v, m, b2b);
      for (int i = 0; i < 16; i++) begin
         for (int g = 1; g < gap; g++) begin
            if (poke) begin
               in_valid = 1'b1;
               in_value = 8'hFF;
               mode     = 1'b1;
            end
            tick();
            if (poke) chk("ready_low_in_run", in_ready, 0);
         end
         in_valid = 1'b0;
         step_en  = 1'b1;
         q_step.push_back('{mask[i], negm[i], mask[i] ? 8'd200 : 8'd0});
         if (i == 15) q_win.push_back(cnt);
         tick();
         step_en = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_spike", spike, 0);
      chk("reset_current", current, 0);
      chk("reset_spike_count", spike_count, 0);
      chk("reset_window_done", window_done, 0);
      rst = 1'b0;
      tick();
      chk("reset_in_ready", in_ready, 1);

      // Abort a rate window (val=128) after five steps: steps 2 and 4 spike.
      accept(8'd128, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step_en = 1'b1;
         q_step.push_back('{i[0], 1'b0, i[0] ? 8'd200 : 8'd0});
         tick();
         step_en = 1'b0;
      end
      chk("pre_abort_count", spike_count, 2);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_spike", spike, 0);
      chk("abort_spike_neg", spike_neg, 0);
      chk("abort_current", current, 0);
      chk("abort_spike_count", spike_count, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_window_done", window_done, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      window(8'd64, 1'b0, 16'h8888, 16'h0000, 4, 1, 1'b0, 1'b0);
      idle(3);
      window(8'd0, 1'b0, 16'h0000, 16'h0000, 0, 1, 1'b0, 1'b0);
      window(8'd255, 1'b0, 16'hFFFE, 16'h0000, 15, 1, 1'b1, 1'b0);
      idle(3);

      window(8'd100, 1'b1, 16'h0001, 16'h0000, 1, 1, 1'b0, 1'b0);
      idle(2);
      window(8'd120, 1'b1, 16'h0001, 16'h0000, 1, 1, 1'b0, 1'b0);
      window(8'd110, 1'b1, 16'h0000, 16'h0001, 0, 1, 1'b1, 1'b0);
      window(8'd80, 1'b1, 16'h0001, 16'h0001, 1, 1, 1'b1, 1'b0);
      idle(2);

      window(8'd128, 1'b0, 16'hAAAA, 16'h0000, 8, 3, 1'b0, 1'b1);
      idle(4);

      chk("step_queue_drained", q_step.size(), 0);
      chk("window_queue_drained", q_win.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Rate/delta spike encoder that turns an 8-bit stimulus value into a spike train over a fixed window of time steps and drives the 8-bit `current` input of the LIF neuron. It sits upstream of the neuron, between the stimulus source (host/IO pins) and the neuron's current injection. Deterministic phase-accumulator coding keeps every spike position predictable and therefore directly checkable.

## Interface
- `WIDTH`, 8: stimulus and current width.
- `WINDOW`, 16: time steps per encoding window (2..256).
- `AMPLITUDE`, 8'd200: current injected on a spike step.
- `DELTA_THR`, 8'd16: change threshold for delta mode.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  stimulus word offered.
- `in_ready`  out  1  encoder can accept a word.
- `in_value`  in  WIDTH  stimulus magnitude.
- `mode`  in  1  sampled with word: 0 = rate, 1 = delta.
- `step_en`  in  1  one-cycle time-step strobe.
- `spike`  out  1  spike for current step.
- `spike_neg`  out  1  delta-mode polarity (1 = decrease).
- `current`  out  WIDTH  `AMPLITUDE` when `spike`, else 0.
- `spike_count`  out  9  spikes emitted in the current/last window.
- `window_done`  out  1  one-cycle pulse at window end.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch `in_value` to `val`, `mode` to `md`; clear `acc`, `step_cnt`, `spike_count`; go RUN. `last_val` is preserved (delta reference).
- RUN: `in_ready`=0; `in_valid` ignored. Each cycle with `step_en`=1:
  - rate: 9-bit sum = `acc` + `val`; `acc` <= sum[7:0]; spike = sum[8]. val=0 never spikes; val=255 spikes 255 of 256 steps.
  - delta: step 0 only: d = `val` − `last_val` (signed 9-bit); spike = |d| ≥ `DELTA_THR`, `spike_neg` = d<0; all later steps spike=0. `last_val` <= `val` at step 0.
  - `spike_count` += spike (saturates at 511); `step_cnt` += 1.
  - when the step making `step_cnt` == `WINDOW` completes: go DONE.
- DONE: one cycle; `window_done`=1, `in_ready`=1. Accepting a word here goes straight to RUN (back-to-back windows); otherwise go IDLE.
- `spike`/`spike_neg`/`current` are registered, valid one cycle after the `step_en` that produced them, held until the next `step_en` or state exit; cleared to 0 in IDLE.
- `spike_count` holds its final value through IDLE until the next accepted word.

## Timing
- Reset (async, any state): state IDLE; `in_ready`=1 after release; `spike`, `spike_neg`, `window_done`=0; `current`=0; `spike_count`=0; `acc`, `step_cnt`=0; `last_val`=0.
- Handshake: transfer on rising edge with `in_valid && in_ready`; `in_ready` is a function of state only (no combinational path from `in_valid`).
- `step_en` in same cycle as the accepting handshake is ignored; first step counted is the next `step_en` in RUN.
- Latency: `step_en` at edge N → `spike`/`current` valid after edge N+1.
- Last step of window at edge N → `window_done` high for the cycle after edge N+1; `spike_count` final at the same time.
- Reset mid-RUN aborts the window; no `window_done` pulse.

## Structure
- Shared package `lif_pkg`: state enum (IDLE/RUN/DONE), `WIDTH`, default `AMPLITUDE`, mode encodings — shared with the neuron and display logic.
- Single module; phase accumulator inline. No sub-module required.

## Test plan
- Reset mid-RUN (val=128, after 5 steps) → all outputs 0, `in_ready`=1, no `window_done`.
- Rate, val=64, WINDOW=16, `step_en` every cycle → spike on steps 4,8,12,16; `spike_count`=4; `current`=200 on those steps; `window_done` one cycle.
- Rate, val=0 then val=255 back-to-back (accepted in DONE) → 0 spikes, then 15 of 16; no IDLE cycle between windows.
- Delta: load 100 then 120 then 110 → window 2: spike, `spike_neg`=0; window 3: no spike (|−10|<16); then load 80 → spike, `spike_neg`=1.
- `step_en` gaps (every 3rd cycle), val=128 → spikes on steps 2,4,…,16 (8 total); outputs held between strobes; `in_valid` during RUN not accepted.
